i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- Pulls sine samples from the dds block by issuing the query strobe, and captures each sample after dds's fixed read latency.
- Serialises each sample as a mono I2S frame to the external audio DAC. The same sample is sent in both left and right slots.
- Owns the audio sample clock: one request per frame, 48 kHz at defaults from a 12.288 MHz clk.

Parameters:
DATA_WDTH, 24, sample width; matches dds output
SLOT_WDTH, 32, bclk periods per channel slot; must be >= DATA_WDTH+1
CLK_DIV, 2, clk cycles per bclk half-period; must be >= 1
REQ_LAT, 3, clk cycles from sample_req pulse to valid sample_in; must be < 6*CLK_DIV

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  run enable, level
sample_in  input  DATA_WDTH  two's-complement sample from dds
sample_req  output  1  one-cycle query strobe to dds
bclk  output  1  I2S bit clock
lrck  output  1  word select: 0 = left, 1 = right
sdata  output  1  serial data, MSB first
busy  output  1  high in PRIME or RUN

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; all counters, hold_reg and frame_sample 0.
- Internal state: div_cnt 0..CLK_DIV-1; bit_cnt 0..2*SLOT_WDTH-1; hold_reg; frame_sample; lat_cnt.
- FSM IDLE: outputs held 0. If en=1, go to PRIME.
- FSM PRIME:
  - sample_req=1 in the first PRIME cycle only.
  - lat_cnt counts REQ_LAT cycles. sample_in is captured into frame_sample exactly REQ_LAT cycles after the pulse cycle.
  - Next cycle: go to RUN with bclk=0, bit_cnt=0, div_cnt=0.
- FSM RUN: div_cnt increments each clk. At div_cnt=CLK_DIV-1 it wraps and bclk toggles, giving a bclk period of 2*CLK_DIV clk.
  - Falling edge (bclk 1->0 cycle): bit_cnt advances, wrapping 2*SLOT_WDTH-1 -> 0. lrck and sdata update in that same cycle, so they are stable on the bclk rising edge.
  - lrck = (bit_cnt >= SLOT_WDTH).
  - Slot position p = bit_cnt mod SLOT_WDTH.
  - sdata = frame_sample[DATA_WDTH-p] for 1 <= p <= DATA_WDTH, else 0. This is the standard I2S one-bit delay with zero padding.
  - Request: sample_req=1 for one clk in the falling-edge cycle where bit_cnt becomes 2*SLOT_WDTH-4. sample_in is captured into hold_reg exactly REQ_LAT clk later; sample_in is ignored in all other cycles.
  - Frame boundary: in the falling-edge cycle where bit_cnt wraps to 0, frame_sample <= hold_reg.
  - Frame length is 4*SLOT_WDTH*CLK_DIV clk (256 at defaults). Requests are spaced exactly one frame apart.
- en=0 in PRIME or RUN (any cycle, mid-frame included):
  - Next cycle: IDLE, all outputs 0.
  - Any pending capture is discarded; frame_sample keeps its value.
  - Re-enable always restarts through PRIME with a fresh request.
- en=1 held in IDLE for one cycle: PRIME entered next cycle. First sample_req appears 1 cycle after en rises.
- Async reset mid-frame: outputs 0 immediately, without waiting for a clk edge. Operation resumes from IDLE after rst_n releases.
- Request and frame-wrap never coincide: the request is at bit 60 and the wrap at bit 0.

Optional Feature:
- Macro I2S_TX_LEFT_JUST_EN.
- Defined: left-justified format. sdata = frame_sample[DATA_WDTH-1-p] for 0 <= p < DATA_WDTH, else 0 (no one-bit delay). lrck polarity, request timing and FSM are unchanged.
- Undefined: standard I2S as specified in Behaviour.

Test Plan:
1. Reset: rst_n=0 with en=1 and random sample_in -> bclk, lrck, sdata, sample_req, busy all 0, including asynchronously mid-cycle.
2. en rises; bench dds model returns 24'hA5C3F1 exactly 3 clk after the request:
   - sample_req pulses 1 cycle after en.
   - Left slot bits 1..24 = A5C3F1 MSB first; bit 0 and bits 25..31 = 0.
   - Right slot identical.
   - lrck low 32 bclk, then high 32 bclk; bclk period 4 clk.
3. Steady state, model returns 24'h000001 then 24'h800000:
   - sample_req every 256 clk, each at the falling edge to bit_cnt 60.
   - Consecutive frames carry 000001 then 800000.
4. Capture window: sample_in = 24'hFFFFFF except 24'h123456 in the exact REQ_LAT cycle -> 123456 is transmitted; ±1 cycle error is caught.
5. en dropped at bit_cnt 40 -> next cycle outputs 0, busy 0, and no further sample_req. Re-enable -> new PRIME request, then frame starts at bit_cnt 0 with lrck=0.
6. With I2S_TX_LEFT_JUST_EN: sample 24'h800001 -> sdata=1 at p=0, 0 at p=1..22, 1 at p=23, 0 at p=24..31.

Source files
------------

// File: rtl/i2s_tx.sv
// Mono I2S transmitter: pulls one sample per frame from dds and sends it in both slots.
// Define I2S_TX_LEFT_JUST_EN for left-justified framing instead of standard I2S.
module i2s_tx #(
    parameter int DATA_WDTH = 24,
    parameter int SLOT_WDTH = 32,
    parameter int CLK_DIV   = 2,
    parameter int REQ_LAT   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DATA_WDTH-1:0] sample_in,
    output logic                 sample_req,
    output logic                 bclk,
    output logic                 lrck,
    output logic                 sdata,
    output logic                 busy
);

    localparam int BIT_W = $clog2(2 * SLOT_WDTH);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LAT_W = $clog2(REQ_LAT + 2);

    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_WDTH - 1);
    localparam logic [BIT_W-1:0] BIT_REQ   = BIT_W'(2 * SLOT_WDTH - 4);
    localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(SLOT_WDTH);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(REQ_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t               state;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_nxt;
    logic [LAT_W-1:0]     lat_cnt;
    logic                 cap_pend;
    logic [DATA_WDTH-1:0] hold_reg;
    logic [DATA_WDTH-1:0] frame_sample;

    // Serial bit for a given frame position; positions outside the data window are zero.
    function automatic logic ser_bit(input logic [DATA_WDTH-1:0] s, input logic [BIT_W-1:0] b);
        int                   p;
        logic [DATA_WDTH-1:0] t;
        p = int'(b);
        if (p >= SLOT_WDTH) p = p - SLOT_WDTH;
        t = '0;
`ifdef I2S_TX_LEFT_JUST_EN
        if (p < DATA_WDTH) t = s >> (DATA_WDTH - 1 - p);
`else
        if (p >= 1 && p <= DATA_WDTH) t = s >> (DATA_WDTH - p);
`endif
        return t[0];
    endfunction

    always_comb begin
        bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            lat_cnt      <= '0;
            cap_pend     <= 1'b0;
            hold_reg     <= '0;
            frame_sample <= '0;
            sample_req   <= 1'b0;
            bclk         <= 1'b0;
            lrck         <= 1'b0;
            sdata        <= 1'b0;
            busy         <= 1'b0;
        end else if (state != IDLE && !en) begin
            // Abort at any point; a pending capture is dropped, frame_sample is kept.
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            lat_cnt    <= '0;
            cap_pend   <= 1'b0;
            sample_req <= 1'b0;
            bclk       <= 1'b0;
            lrck       <= 1'b0;
            sdata      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sample_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state      <= PRIME;
                        sample_req <= 1'b1;
                        busy       <= 1'b1;
                        lat_cnt    <= '0;
                    end
                end
                PRIME: begin
                    if (lat_cnt == LAT_LAST) begin
                        frame_sample <= sample_in;
                        state        <= RUN;
                        bclk         <= 1'b0;
                        bit_cnt      <= '0;
                        div_cnt      <= '0;
                        lrck         <= 1'b0;
                        sdata        <= ser_bit(sample_in, BIT_W'(0));
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                RUN: begin
                    if (cap_pend) begin
                        if (lat_cnt == LAT_LAST) begin
                            hold_reg <= sample_in;
                            cap_pend <= 1'b0;
                        end else begin
                            lat_cnt <= lat_cnt + LAT_W'(1);
                        end
                    end
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bclk    <= ~bclk;
                        // Falling edge: advance the bit so lrck/sdata settle before the next rise.
                        if (bclk) begin
                            bit_cnt <= bit_nxt;
                            lrck    <= (bit_nxt >= BIT_RIGHT);
                            if (bit_nxt == '0) begin
                                frame_sample <= hold_reg;
                                sdata        <= ser_bit(hold_reg, bit_nxt);
                            end else begin
                                sdata <= ser_bit(frame_sample, bit_nxt);
                            end
                            if (bit_nxt == BIT_REQ) begin
                                sample_req <= 1'b1;
                                cap_pend   <= 1'b1;
                                lat_cnt    <= '0;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: dds response model, frame decoder and per-scenario checks.
module tb_i2s_tx;

    localparam int DW = 24;
    localparam int SW = 32;
    localparam int CD = 2;
    localparam int LAT = 3;
    localparam int FB = 2 * SW;
    localparam int FRAME_CLK = 4 * SW * CD;
    localparam logic [FB-1:0] LR_PAT = {{SW{1'b1}}, {SW{1'b0}}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          sample_req, bclk, lrck, sdata, busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Decoder and dds model state
    int            rise_in_frame = 0;
    int            last_rise = -1;
    int            min_per = 1000;
    int            max_per = 0;
    logic          prev_bclk = 1'b0;
    logic [FB-1:0] cur_sd = '0;
    logic [FB-1:0] cur_lr = '0;
    logic [FB-1:0] frame_sd_q[$];
    logic [FB-1:0] frame_lr_q[$];
    int            req_cyc_q[$];
    int            req_pos_q[$];
    logic [DW-1:0] resp_q[$];
    logic [DW-1:0] exp_q[$];
    logic          dds_pend = 1'b0;
    int            dds_at = 0;
    logic [DW-1:0] dds_val = '0;
    logic          garbage_ff = 1'b0;

    i2s_tx #(.DATA_WDTH(DW), .SLOT_WDTH(SW), .CLK_DIV(CD), .REQ_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sample_in(sample_in),
        .sample_req(sample_req), .bclk(bclk), .lrck(lrck), .sdata(sdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected 64-bit frame, bit i = value on the i-th bclk rise of the frame.
    function automatic logic [FB-1:0] exp_frame(input logic [DW-1:0] s);
        logic [FB-1:0] e;
        logic [DW-1:0] t;
        int p;
        e = '0;
        for (int b = 0; b < FB; b++) begin
            p = b % SW;
            t = '0;
`ifdef I2S_TX_LEFT_JUST_EN
            if (p < DW) t = s >> (DW - 1 - p);
`else
            if (p >= 1 && p <= DW) t = s >> (DW - p);
`endif
            e = {t[0], e[FB-1:1]};
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!busy) begin
            rise_in_frame = 0;
            prev_bclk = 1'b0;
            last_rise = -1;
        end else begin
            if (bclk && !prev_bclk) begin
                if (last_rise >= 0) begin
                    if (cyc - last_rise < min_per) min_per = cyc - last_rise;
                    if (cyc - last_rise > max_per) max_per = cyc - last_rise;
                end
                last_rise = cyc;
                cur_sd = {sdata, cur_sd[FB-1:1]};
                cur_lr = {lrck, cur_lr[FB-1:1]};
                rise_in_frame++;
                if (rise_in_frame == FB) begin
                    frame_sd_q.push_back(cur_sd);
                    frame_lr_q.push_back(cur_lr);
                    rise_in_frame = 0;
                end
            end
            prev_bclk = bclk;
        end
        if (sample_req) begin
            req_cyc_q.push_back(cyc);
            req_pos_q.push_back(rise_in_frame);
            if (resp_q.size() > 0) dds_val = resp_q.pop_front();
            else dds_val = DW'($urandom);
            exp_q.push_back(dds_val);
            dds_pend = 1'b1;
            dds_at = cyc + LAT;
        end
        if (dds_pend && cyc == dds_at) begin
            sample_in = dds_val;
            dds_pend = 1'b0;
        end else if (garbage_ff) begin
            sample_in = '1;
        end else begin
            sample_in = DW'($urandom);
        end
    end

    task automatic clear_state();
        frame_sd_q.delete();
        frame_lr_q.delete();
        req_cyc_q.delete();
        req_pos_q.delete();
        resp_q.delete();
        exp_q.delete();
        min_per = 1000;
        max_per = 0;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        while (frame_sd_q.size() < n && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        ok = (frame_sd_q.size() >= n);
    endtask

    task automatic wait_req(input int budget, output int got);
        while (req_cyc_q.size() == 0 && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        got = (req_cyc_q.size() > 0) ? req_cyc_q[0] : -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if ({sample_req, bclk, lrck, sdata, busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b required 00000", {sample_req, bclk, lrck, sdata, busy});
        end
        en = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_first_frame();
        int en_cyc, got;
        bit ok;
        logic [FB-1:0] sd, lr, e;
        clear_state();
        resp_q.push_back(24'hA5C3F1);
        en = 1'b1;
        en_cyc = cyc;
        wait_req(10, got);
        vectors++;
        if (got !== en_cyc + 1) begin
            miscompares++;
            $display("FAIL first_req_cycle: got %0d required %0d", got, en_cyc + 1);
        end
        wait_frames(1, 700, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL first_frame_timeout: frames %0d required 1", frame_sd_q.size());
        end else begin
            sd = frame_sd_q.pop_front();
            lr = frame_lr_q.pop_front();
            void'(exp_q.pop_front());
            e = exp_frame(24'hA5C3F1);
            vectors += 3;
            if (sd[SW-1:0] !== e[SW-1:0]) begin
                miscompares++;
                $display("FAIL first_left_slot: got %h required %h", sd[SW-1:0], e[SW-1:0]);
            end
            if (sd[FB-1:SW] !== e[FB-1:SW]) begin
                miscompares++;
                $display("FAIL first_right_slot: got %h required %h", sd[FB-1:SW], e[FB-1:SW]);
            end
            if (lr !== LR_PAT) begin
                miscompares++;
                $display("FAIL first_lrck: got %h required %h", lr, LR_PAT);
            end
        end
        vectors += 2;
        if (min_per !== 2 * CD) begin
            miscompares++;
            $display("FAIL bclk_period_min: got %0d required %0d", min_per, 2 * CD);
        end
        if (max_per !== 2 * CD) begin
            miscompares++;
            $display("FAIL bclk_period_max: got %0d required %0d", max_per, 2 * CD);
        end
    endtask

    task automatic test_steady();
        bit ok;
        int idx_a, idx_b;
        logic [FB-1:0] sd, lr;
        logic [DW-1:0] v;
        idx_a = -10;
        idx_b = -20;
        resp_q.push_back(24'h000001);
        resp_q.push_back(24'h800000);
        for (int f = 0; f < 4; f++) begin
            wait_frames(1, 700, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL steady_frame_timeout: frame %0d", f);
                break;
            end
            sd = frame_sd_q.pop_front();
            lr = frame_lr_q.pop_front();
            v = exp_q.pop_front();
            if (v == 24'h000001) idx_a = f;
            if (v == 24'h800000) idx_b = f;
            vectors += 2;
            if (sd !== exp_frame(v)) begin
                miscompares++;
                $display("FAIL steady_sdata: sample %h got %h required %h", v, sd, exp_frame(v));
            end
            if (lr !== LR_PAT) begin
                miscompares++;
                $display("FAIL steady_lrck: got %h required %h", lr, LR_PAT);
            end
        end
        vectors++;
        if (idx_b != idx_a + 1 || idx_a < 0) begin
            miscompares++;
            $display("FAIL steady_order: frame of 000001 %0d, frame of 800000 %0d required consecutive", idx_a, idx_b);
        end
        for (int i = 1; i < req_cyc_q.size(); i++) begin
            vectors++;
            if (req_pos_q[i] !== FB - 4) begin
                miscompares++;
                $display("FAIL req_bit_pos: req %0d got %0d required %0d", i, req_pos_q[i], FB - 4);
            end
            if (i >= 2) begin
                vectors++;
                if (req_cyc_q[i] - req_cyc_q[i-1] !== FRAME_CLK) begin
                    miscompares++;
                    $display("FAIL req_spacing: req %0d got %0d required %0d", i, req_cyc_q[i] - req_cyc_q[i-1], FRAME_CLK);
                end
            end
        end
    endtask

    task automatic test_value_in_stream(input logic [DW-1:0] target, input bit garbage);
        bit ok, found;
        logic [FB-1:0] sd, lr;
        logic [DW-1:0] v;
        found = 1'b0;
        garbage_ff = garbage;
        resp_q.push_back(target);
        for (int f = 0; f < 4 && !found; f++) begin
            wait_frames(1, 700, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL stream_frame_timeout: target %h", target);
                break;
            end
            sd = frame_sd_q.pop_front();
            lr = frame_lr_q.pop_front();
            v = exp_q.pop_front();
            if (v == target) found = 1'b1;
            vectors += 2;
            if (sd !== exp_frame(v)) begin
                miscompares++;
                $display("FAIL stream_sdata: sample %h got %h required %h", v, sd, exp_frame(v));
            end
            if (lr !== LR_PAT) begin
                miscompares++;
                $display("FAIL stream_lrck: got %h required %h", lr, LR_PAT);
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL stream_target: %h got not transmitted required transmitted", target);
        end
        garbage_ff = 1'b0;
    endtask

    task automatic test_en_drop();
        int budget, nreq, en_cyc, got;
        bit ok;
        logic [FB-1:0] sd, lr;
        logic [DW-1:0] v;
        budget = 400;
        while (!(busy && rise_in_frame == 41) && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        vectors++;
        if (budget == 0) begin
            miscompares++;
            $display("FAIL drop_bit40_timeout: rise %0d required 41", rise_in_frame);
        end
        en = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if ({sample_req, bclk, lrck, sdata, busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL drop_outputs: got %b required 00000", {sample_req, bclk, lrck, sdata, busy});
        end
        nreq = req_cyc_q.size();
        repeat (300) @(negedge clk);
        #1;
        vectors++;
        if (req_cyc_q.size() !== nreq) begin
            miscompares++;
            $display("FAIL drop_no_req: got %0d requests required %0d", req_cyc_q.size(), nreq);
        end
        clear_state();
        v = DW'($urandom);
        resp_q.push_back(v);
        en = 1'b1;
        en_cyc = cyc;
        wait_req(10, got);
        vectors++;
        if (got !== en_cyc + 1) begin
            miscompares++;
            $display("FAIL reenable_req_cycle: got %0d required %0d", got, en_cyc + 1);
        end
        wait_frames(1, 700, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL reenable_frame_timeout: frames %0d required 1", frame_sd_q.size());
        end else begin
            sd = frame_sd_q.pop_front();
            lr = frame_lr_q.pop_front();
            void'(exp_q.pop_front());
            vectors += 2;
            if (sd !== exp_frame(v)) begin
                miscompares++;
                $display("FAIL reenable_sdata: got %h required %h", sd, exp_frame(v));
            end
            if (lr !== LR_PAT) begin
                miscompares++;
                $display("FAIL reenable_lrck: got %h required %h", lr, LR_PAT);
            end
        end
    endtask

    task automatic test_async_reset();
        int budget, rel_cyc, got;
        budget = 100;
        while (!(busy && bclk) && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        vectors++;
        if (budget == 0) begin
            miscompares++;
            $display("FAIL async_setup_timeout: busy %b bclk %b required 1 1", busy, bclk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({sample_req, bclk, lrck, sdata, busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL async_reset_outputs: got %b required 00000", {sample_req, bclk, lrck, sdata, busy});
        end
        @(negedge clk); #1;
        clear_state();
        rst_n = 1'b1;
        rel_cyc = cyc;
        wait_req(10, got);
        vectors++;
        if (got !== rel_cyc + 1) begin
            miscompares++;
            $display("FAIL async_restart_req: got %0d required %0d", got, rel_cyc + 1);
        end
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_steady();
        test_value_in_stream(24'h123456, 1'b1);
        test_en_drop();
        test_value_in_stream(24'h800001, 1'b0);
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
